// File: rtl/risc_v_pkg.sv
// -----------------------------------------------------------------------------
// risc_v_pkg
// Shared types and default widths for the processor memory-port arbiter.
//   arb_state_t : arbiter FSM states (IDLE, REQ, RSP)
//   arb_owner_t : which pipeline stage owns the current bus transaction
// -----------------------------------------------------------------------------
package risc_v_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int ADDR_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } arb_owner_t;

endpackage

// File: rtl/mem_arb_watchdog.sv
// -----------------------------------------------------------------------------
// mem_arb_watchdog
// Loadable transaction timeout counter for the memory-port arbiter.
// Ports:
//   clk      : system clock, rising edge
//   reset    : asynchronous, active-high reset
//   i_load   : clear the counter (new transaction granted)
//   i_en     : count this cycle (transaction outstanding)
//   o_expire : the current outstanding cycle is the TIMEOUT-th one
// -----------------------------------------------------------------------------
module mem_arb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic i_load,
    input  logic i_en,
    output logic o_expire
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    // The count is 0 in the first outstanding cycle, so TIMEOUT-1 marks the
    // last cycle; the abort takes effect on the edge where it would reach TIMEOUT.
    assign o_expire = i_en && (r_count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one unified instruction/data memory port between the IF stage (fetch)
// and the MEM stage (load/store). One transaction at a time; DM wins ties.
// Ports:
//   clk, reset                    : clock / asynchronous active-high reset
//   if_req_*, if_flush            : fetch request (level) and redirect flush
//   if_rsp_valid/data, if_stall   : fetch response strobe, instruction, stall
//   dm_req_*                      : load/store request (level)
//   dm_rsp_valid/rdata, dm_stall  : data response strobe, load data, stall
//   mem_req_*, mem_rsp_*          : memory-side valid/ready request, response
//   bus_err                       : one-cycle timeout abort strobe
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import risc_v_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req_valid,
    input  logic [ADDR_W-1:0] if_req_addr,
    input  logic              if_flush,
    output logic              if_rsp_valid,
    output logic [XLEN-1:0]   if_rsp_data,
    output logic              if_stall,
    input  logic              dm_req_valid,
    input  logic              dm_req_we,
    input  logic [XLEN/8-1:0] dm_req_be,
    input  logic [ADDR_W-1:0] dm_req_addr,
    input  logic [XLEN-1:0]   dm_req_wdata,
    output logic              dm_rsp_valid,
    output logic [XLEN-1:0]   dm_rsp_rdata,
    output logic              dm_stall,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_we,
    output logic [XLEN/8-1:0] mem_req_be,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [XLEN-1:0]   mem_req_wdata,
    input  logic              mem_rsp_valid,
    input  logic [XLEN-1:0]   mem_rsp_rdata,
    output logic              bus_err
);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    arb_owner_t        r_owner;
    logic              r_discard;
    logic              r_we;
    logic [XLEN/8-1:0] r_be;
    logic [ADDR_W-1:0] r_addr;
    logic [XLEN-1:0]   r_wdata;
    logic              r_if_rsp_valid;
    logic [XLEN-1:0]   r_if_rsp_data;
    logic              r_dm_rsp_valid;
    logic [XLEN-1:0]   r_dm_rsp_rdata;
    logic              r_bus_err;

    logic w_grant_dm;
    logic w_grant_if;
    logic w_done;
    logic w_abort;
    logic w_finish;
    logic w_expire;
    logic w_flush_hit;
    logic w_drop;
    logic w_if_fin;
    logic w_dm_fin;

    mem_arb_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_grant_dm | w_grant_if),
        .i_en    (r_state != IDLE),
        .o_expire(w_expire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A requester whose response strobe is high this cycle is still holding a
    // request that was just served, so it must not be re-granted.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_dm  = 1'b0;
        w_grant_if  = 1'b0;
        w_done      = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            IDLE: begin
                if (dm_req_valid && !r_dm_rsp_valid) begin
                    w_grant_dm  = 1'b1;
                    w_state_nxt = REQ;
                end else if (if_req_valid && !r_if_rsp_valid) begin
                    w_grant_if  = 1'b1;
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                // A response here is illegal and ignored; only expiry or
                // acceptance moves the FSM.
                if (w_expire) begin
                    w_abort     = 1'b1;
                    w_state_nxt = IDLE;
                end else if (mem_req_ready) begin
                    w_state_nxt = RSP;
                end
            end
            RSP: begin
                // A real response in the last allowed cycle still completes.
                if (mem_rsp_valid) begin
                    w_done      = 1'b1;
                    w_state_nxt = IDLE;
                end else if (w_expire) begin
                    w_abort     = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_finish    = w_done | w_abort;
    // A flush arriving in the completion cycle itself must also drop the response.
    assign w_flush_hit = if_flush && (r_owner == OWN_IF) && (r_state != IDLE);
    assign w_drop      = r_discard | w_flush_hit;
    assign w_if_fin    = w_finish && (r_owner == OWN_IF) && !w_drop;
    assign w_dm_fin    = w_finish && (r_owner == OWN_DM);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_owner        <= OWN_NONE;
            r_discard      <= 1'b0;
            r_we           <= 1'b0;
            r_be           <= '0;
            r_addr         <= '0;
            r_wdata        <= '0;
            r_if_rsp_valid <= 1'b0;
            r_if_rsp_data  <= '0;
            r_dm_rsp_valid <= 1'b0;
            r_dm_rsp_rdata <= '0;
            r_bus_err      <= 1'b0;
        end else begin
            r_if_rsp_valid <= w_if_fin;
            r_dm_rsp_valid <= w_dm_fin;
            r_bus_err      <= w_abort;

            if (w_if_fin) begin
                r_if_rsp_data <= w_done ? mem_rsp_rdata : '0;
            end
            if (w_dm_fin) begin
                r_dm_rsp_rdata <= w_done ? mem_rsp_rdata : '0;
            end

            if (w_finish) begin
                r_discard <= 1'b0;
                r_owner   <= OWN_NONE;
            end else if (w_flush_hit) begin
                r_discard <= 1'b1;
            end

            if (w_grant_dm) begin
                r_owner <= OWN_DM;
                r_we    <= dm_req_we;
                r_be    <= dm_req_be;
                r_addr  <= dm_req_addr;
                r_wdata <= dm_req_wdata;
            end else if (w_grant_if) begin
                r_owner <= OWN_IF;
                r_we    <= 1'b0;
                r_be    <= '1;
                r_addr  <= if_req_addr;
                r_wdata <= '0;
            end
        end
    end

    assign mem_req_valid = (r_state == REQ);
    assign mem_req_we    = r_we;
    assign mem_req_be    = r_be;
    assign mem_req_addr  = r_addr;
    assign mem_req_wdata = r_wdata;

    assign if_rsp_valid  = r_if_rsp_valid;
    assign if_rsp_data   = r_if_rsp_data;
    assign dm_rsp_valid  = r_dm_rsp_valid;
    assign dm_rsp_rdata  = r_dm_rsp_rdata;
    assign bus_err       = r_bus_err;

    assign if_stall = if_req_valid & ~r_if_rsp_valid;
    assign dm_stall = dm_req_valid & ~r_dm_rsp_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req_valid;
    logic [31:0] if_req_addr;
    logic        if_flush;
    logic        if_rsp_valid;
    logic [31:0] if_rsp_data;
    logic        if_stall;
    logic        dm_req_valid;
    logic        dm_req_we;
    logic [3:0]  dm_req_be;
    logic [31:0] dm_req_addr;
    logic [31:0] dm_req_wdata;
    logic        dm_rsp_valid;
    logic [31:0] dm_rsp_rdata;
    logic        dm_stall;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_we;
    logic [3:0]  mem_req_be;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_rdata;
    logic        bus_err;

    int n_cmp = 0;
    int n_bad = 0;

    mem_port_arbiter #(
        .XLEN   (32),
        .ADDR_W (32),
        .TIMEOUT(8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .if_req_valid (if_req_valid),
        .if_req_addr  (if_req_addr),
        .if_flush     (if_flush),
        .if_rsp_valid (if_rsp_valid),
        .if_rsp_data  (if_rsp_data),
        .if_stall     (if_stall),
        .dm_req_valid (dm_req_valid),
        .dm_req_we    (dm_req_we),
        .dm_req_be    (dm_req_be),
        .dm_req_addr  (dm_req_addr),
        .dm_req_wdata (dm_req_wdata),
        .dm_rsp_valid (dm_rsp_valid),
        .dm_rsp_rdata (dm_rsp_rdata),
        .dm_stall     (dm_stall),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_req_we   (mem_req_we),
        .mem_req_be   (mem_req_be),
        .mem_req_addr (mem_req_addr),
        .mem_req_wdata(mem_req_wdata),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_rdata(mem_rsp_rdata),
        .bus_err      (bus_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, limit 200000", $time);
        $fatal(1, "bench time limit exceeded");
    end

    // Drive point: just after the active edge. Check point: falling edge.
    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        if_req_valid = 0; if_req_addr = '0; if_flush = 0;
        dm_req_valid = 0; dm_req_we = 0; dm_req_be = '0; dm_req_addr = '0; dm_req_wdata = '0;
        mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_rdata = '0;
        mid();
        n_cmp++;
        if ({mem_req_valid, if_rsp_valid, dm_rsp_valid, bus_err, if_stall, dm_stall} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {mem_req_valid, if_rsp_valid, dm_rsp_valid, bus_err, if_stall, dm_stall});
        end
        n_cmp++;
        if ({mem_req_addr, mem_req_wdata, if_rsp_data, dm_rsp_rdata, mem_req_we, mem_req_be} !== '0) begin
            n_bad++;
            $display("FAIL reset_data: addr %h wdata %h ifd %h dmd %h expected all 0",
                     mem_req_addr, mem_req_wdata, if_rsp_data, dm_rsp_rdata);
        end
        adv();
        reset = 1'b0;
        mid();
        n_cmp++;
        if (mem_req_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_after_reset: mem_req_valid %b expected 0", mem_req_valid);
        end
    endtask

    task automatic test_if_fetch();
        adv();                                  // T
        if_req_valid = 1; if_req_addr = 32'h0000_0040;
        mid();
        n_cmp++;
        if ({if_stall, mem_req_valid} !== 2'b10) begin
            n_bad++;
            $display("FAIL fetch_T: stall/valid %b expected 10", {if_stall, mem_req_valid});
        end
        adv();                                  // T+1
        mem_req_ready = 1;
        mid();
        n_cmp++;
        if ({mem_req_valid, mem_req_we, mem_req_be, mem_req_addr, if_stall} !== {1'b1, 1'b0, 4'hF, 32'h40, 1'b1}) begin
            n_bad++;
            $display("FAIL fetch_req: valid %b we %b be %h addr %h stall %b expected 1 0 f 00000040 1",
                     mem_req_valid, mem_req_we, mem_req_be, mem_req_addr, if_stall);
        end
        adv();                                  // T+2
        mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_rdata = 32'h0050_0093;
        mid();
        n_cmp++;
        if ({mem_req_valid, if_rsp_valid, if_stall} !== 3'b001) begin
            n_bad++;
            $display("FAIL fetch_T2: valid/rsp/stall %b expected 001", {mem_req_valid, if_rsp_valid, if_stall});
        end
        adv();                                  // T+3
        mem_rsp_valid = 0; mem_rsp_rdata = '0;
        mid();
        n_cmp++;
        if ({if_rsp_valid, if_rsp_data, if_stall} !== {1'b1, 32'h0050_0093, 1'b0}) begin
            n_bad++;
            $display("FAIL fetch_rsp: valid %b data %h stall %b expected 1 00500093 0",
                     if_rsp_valid, if_rsp_data, if_stall);
        end
        adv();                                  // T+4
        if_req_valid = 0;
        mid();
        n_cmp++;
        if ({if_rsp_valid, if_rsp_data, mem_req_valid} !== {1'b0, 32'h0050_0093, 1'b0}) begin
            n_bad++;
            $display("FAIL fetch_hold: valid %b data %h memvalid %b expected 0 00500093 0",
                     if_rsp_valid, if_rsp_data, mem_req_valid);
        end
    endtask

    task automatic test_priority();
        adv();                                  // T
        if_req_valid = 1; if_req_addr = 32'h44;
        dm_req_valid = 1; dm_req_we = 1; dm_req_be = 4'hF;
        dm_req_addr = 32'h100; dm_req_wdata = 32'hDEAD_BEEF;
        mid();
        n_cmp++;
        if ({if_stall, dm_stall, mem_req_valid} !== 3'b110) begin
            n_bad++;
            $display("FAIL prio_T: stalls/valid %b expected 110", {if_stall, dm_stall, mem_req_valid});
        end
        adv();                                  // T+1
        mem_req_ready = 1;
        mid();
        n_cmp++;
        if ({mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata} !== {1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF}) begin
            n_bad++;
            $display("FAIL prio_dm_req: valid %b we %b addr %h wdata %h expected 1 1 00000100 deadbeef",
                     mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata);
        end
        adv();                                  // T+2
        mem_req_ready = 0; mem_rsp_valid = 1;
        adv();                                  // T+3
        mem_rsp_valid = 0;
        mid();
        n_cmp++;
        if ({dm_rsp_valid, dm_stall, if_stall, if_rsp_valid, mem_req_valid} !== 5'b10100) begin
            n_bad++;
            $display("FAIL prio_dm_ack: dmv/dms/ifs/ifv/memv %b expected 10100",
                     {dm_rsp_valid, dm_stall, if_stall, if_rsp_valid, mem_req_valid});
        end
        adv();                                  // T+4: IF granted in T+3
        dm_req_valid = 0; dm_req_we = 0; mem_req_ready = 1;
        mid();
        n_cmp++;
        if ({mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, dm_rsp_valid, if_stall} !==
            {1'b1, 1'b0, 32'h44, 32'h0, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL prio_if_req: valid %b we %b addr %h wdata %h dmv %b ifs %b expected 1 0 00000044 00000000 0 1",
                     mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, dm_rsp_valid, if_stall);
        end
        adv();                                  // T+5
        mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_rdata = 32'h1111_1111;
        mid();
        n_cmp++;
        if ({if_stall, if_rsp_valid} !== 2'b10) begin
            n_bad++;
            $display("FAIL prio_if_wait: stall/valid %b expected 10", {if_stall, if_rsp_valid});
        end
        adv();                                  // T+6
        mem_rsp_valid = 0; mem_rsp_rdata = '0;
        mid();
        n_cmp++;
        if ({if_rsp_valid, if_rsp_data, if_stall} !== {1'b1, 32'h1111_1111, 1'b0}) begin
            n_bad++;
            $display("FAIL prio_if_rsp: valid %b data %h stall %b expected 1 11111111 0",
                     if_rsp_valid, if_rsp_data, if_stall);
        end
        adv();
        if_req_valid = 0;
    endtask

    task automatic test_ready_stall();
        adv();                                  // T
        dm_req_valid = 1; dm_req_we = 0; dm_req_be = 4'hF; dm_req_addr = 32'h200; dm_req_wdata = '0;
        for (int k = 1; k <= 4; k++) begin      // T+1 .. T+4
            adv();
            mem_req_ready = (k == 4);
            mid();
            n_cmp++;
            if ({mem_req_valid, mem_req_we, mem_req_be, mem_req_addr, dm_stall} !== {1'b1, 1'b0, 4'hF, 32'h200, 1'b1}) begin
                n_bad++;
                $display("FAIL ready_hold_%0d: valid %b we %b be %h addr %h stall %b expected 1 0 f 00000200 1",
                         k, mem_req_valid, mem_req_we, mem_req_be, mem_req_addr, dm_stall);
            end
        end
        adv();                                  // T+5
        mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_rdata = 32'hCAFE_F00D;
        mid();
        n_cmp++;
        if (mem_req_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL ready_drop: mem_req_valid %b expected 0", mem_req_valid);
        end
        adv();                                  // T+6
        mem_rsp_valid = 0; mem_rsp_rdata = '0;
        mid();
        n_cmp++;
        if ({dm_rsp_valid, dm_rsp_rdata} !== {1'b1, 32'hCAFE_F00D}) begin
            n_bad++;
            $display("FAIL ready_load: valid %b data %h expected 1 cafef00d", dm_rsp_valid, dm_rsp_rdata);
        end
        adv();
        dm_req_valid = 0;
        mid();
        n_cmp++;
        if ({dm_rsp_valid, dm_rsp_rdata, mem_req_valid} !== {1'b0, 32'hCAFE_F00D, 1'b0}) begin
            n_bad++;
            $display("FAIL ready_hold_data: valid %b data %h memv %b expected 0 cafef00d 0",
                     dm_rsp_valid, dm_rsp_rdata, mem_req_valid);
        end
    endtask

    task automatic test_flush();
        adv();                                  // T
        if_req_valid = 1; if_req_addr = 32'h48;
        adv();                                  // T+1
        mem_req_ready = 1;
        adv();                                  // T+2 (RSP)
        mem_req_ready = 0; if_flush = 1;
        adv();                                  // T+3
        if_flush = 0; mem_rsp_valid = 1; mem_rsp_rdata = 32'h1234_5678;
        mid();
        n_cmp++;
        if (if_rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_T3: if_rsp_valid %b expected 0", if_rsp_valid);
        end
        adv();                                  // T+4: IDLE, redirected fetch
        mem_rsp_valid = 0; mem_rsp_rdata = '0; if_req_addr = 32'h80;
        mid();
        n_cmp++;
        if ({if_rsp_valid, if_rsp_data, mem_req_valid, if_stall} !== {1'b0, 32'h1111_1111, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL flush_drop: valid %b data %h memv %b stall %b expected 0 11111111 0 1",
                     if_rsp_valid, if_rsp_data, mem_req_valid, if_stall);
        end
        adv();                                  // T+5
        mem_req_ready = 1;
        mid();
        n_cmp++;
        if ({mem_req_valid, mem_req_addr} !== {1'b1, 32'h80}) begin
            n_bad++;
            $display("FAIL flush_refetch: valid %b addr %h expected 1 00000080", mem_req_valid, mem_req_addr);
        end
        adv();                                  // T+6
        mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_rdata = 32'h0AAA_AAAA;
        adv();                                  // T+7
        mem_rsp_valid = 0; mem_rsp_rdata = '0;
        mid();
        n_cmp++;
        if ({if_rsp_valid, if_rsp_data} !== {1'b1, 32'h0AAA_AAAA}) begin
            n_bad++;
            $display("FAIL flush_new_rsp: valid %b data %h expected 1 0aaaaaaa", if_rsp_valid, if_rsp_data);
        end
        adv();
        if_req_valid = 0;
    endtask

    task automatic test_timeout();
        adv();                                  // T
        dm_req_valid = 1; dm_req_we = 0; dm_req_be = 4'hF; dm_req_addr = 32'h300;
        adv();                                  // T+1: REQ
        mem_req_ready = 1;
        adv();                                  // T+2: RSP
        mem_req_ready = 0;
        mid();
        for (int k = 3; k <= 9; k++) begin      // T+2 .. T+8
            n_cmp++;
            if ({bus_err, dm_rsp_valid} !== 2'b00) begin
                n_bad++;
                $display("FAIL tmo_early_%0d: bus_err/dm_rsp_valid %b expected 00", k - 1, {bus_err, dm_rsp_valid});
            end
            adv();
            mid();
        end
        // now in T+9
        n_cmp++;
        if ({bus_err, dm_rsp_valid, dm_rsp_rdata, mem_req_valid} !== {1'b1, 1'b1, 32'h0, 1'b0}) begin
            n_bad++;
            $display("FAIL tmo_abort: err %b valid %b data %h memv %b expected 1 1 00000000 0",
                     bus_err, dm_rsp_valid, dm_rsp_rdata, mem_req_valid);
        end
        adv();                                  // T+10: late response
        dm_req_valid = 0; mem_rsp_valid = 1; mem_rsp_rdata = 32'h5555_5555;
        mid();
        n_cmp++;
        if ({bus_err, dm_rsp_valid} !== 2'b00) begin
            n_bad++;
            $display("FAIL tmo_one_cycle: err/valid %b expected 00", {bus_err, dm_rsp_valid});
        end
        adv();                                  // T+11
        mem_rsp_valid = 0; mem_rsp_rdata = '0;
        mid();
        n_cmp++;
        if ({bus_err, dm_rsp_valid, if_rsp_valid, dm_rsp_rdata, mem_req_valid} !== {3'b000, 32'h0, 1'b0}) begin
            n_bad++;
            $display("FAIL tmo_late_ignored: err %b dmv %b ifv %b data %h memv %b expected 0 0 0 00000000 0",
                     bus_err, dm_rsp_valid, if_rsp_valid, dm_rsp_rdata, mem_req_valid);
        end
    endtask

    task automatic test_reset_mid();
        adv();                                  // T
        if_req_valid = 1; if_req_addr = 32'h500;
        adv();                                  // T+1
        mem_req_ready = 1;
        adv();                                  // T+2: RSP
        mem_req_ready = 0;
        mid();
        n_cmp++;
        if (mem_req_addr !== 32'h500) begin
            n_bad++;
            $display("FAIL rstmid_pre: mem_req_addr %h expected 00000500", mem_req_addr);
        end
        reset = 1; if_req_valid = 0;
        #1;
        n_cmp++;
        if ({mem_req_valid, if_rsp_valid, dm_rsp_valid, bus_err, if_stall, dm_stall,
             mem_req_we, mem_req_be, mem_req_addr, if_rsp_data, dm_rsp_rdata} !== '0) begin
            n_bad++;
            $display("FAIL rstmid_async: addr %h ifd %h dmd %h memv %b expected all 0",
                     mem_req_addr, if_rsp_data, dm_rsp_rdata, mem_req_valid);
        end
        adv();
        reset = 0; mem_rsp_valid = 1; mem_rsp_rdata = 32'h7777_7777;
        adv();
        mem_rsp_valid = 0; mem_rsp_rdata = '0;
        mid();
        n_cmp++;
        if ({if_rsp_valid, dm_rsp_valid, bus_err, mem_req_valid, if_rsp_data} !== {4'b0000, 32'h0}) begin
            n_bad++;
            $display("FAIL rstmid_stray: ifv %b dmv %b err %b memv %b ifd %h expected 0 0 0 0 00000000",
                     if_rsp_valid, dm_rsp_valid, bus_err, mem_req_valid, if_rsp_data);
        end
    endtask

    initial begin
        test_reset();
        test_if_fetch();
        test_priority();
        test_ready_stall();
        test_flush();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified instruction/data memory port between the IF stage (fetch, read-only) and the MEM stage (load/store).
- Grants one transaction at a time and drives the memory request/response handshake.
- Returns responses to the owning stage and generates the per-stage stall signals consumed by the pipeline and hazard logic.
- Sits between the IF/MEM stages and the memory model/controller at the processor top level.

Parameters:
- XLEN, 32, data width of fetch/load/store words.
- ADDR_W, 32, byte address width.
- TIMEOUT, 255, max cycles from grant to response before error abort (counter width = clog2(TIMEOUT+1)).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- if_req_valid  in  1  fetch request; level, held until if_rsp_valid.
- if_req_addr  in  ADDR_W  fetch address.
- if_flush  in  1  IF flush (branch/jump redirect).
- if_rsp_valid  out  1  one-cycle fetch response strobe.
- if_rsp_data  out  XLEN  instruction word.
- if_stall  out  1  fetch stall.
- dm_req_valid  in  1  data request; level, held until dm_rsp_valid.
- dm_req_we  in  1  1 = store, 0 = load.
- dm_req_be  in  XLEN/8  byte enables.
- dm_req_addr  in  ADDR_W  data address.
- dm_req_wdata  in  XLEN  store data.
- dm_rsp_valid  out  1  one-cycle data response strobe (load data or store ack).
- dm_rsp_rdata  out  XLEN  load data.
- dm_stall  out  1  MEM-stage stall.
- mem_req_valid  out  1  memory request valid.
- mem_req_ready  in  1  memory accepts request.
- mem_req_we  out  1  write enable.
- mem_req_be  out  XLEN/8  byte enables.
- mem_req_addr  out  ADDR_W  address.
- mem_req_wdata  out  XLEN  write data.
- mem_rsp_valid  in  1  memory response (read data or write ack).
- mem_rsp_rdata  in  XLEN  read data.
- bus_err  out  1  one-cycle timeout error strobe.

Behaviour:
- Single clock domain (clk); reset is asynchronous, active-high.
- Reset: state IDLE, owner none, discard 0, counter 0, all outputs 0. Reset asserted mid-transaction abandons it; any later mem_rsp_valid arriving in IDLE is ignored.
- FSM states:
  - IDLE: grant if a requester is eligible. DM has priority over IF (older instruction). A requester whose rsp_valid is high this cycle is ineligible. On grant: latch owner, we/be/addr/wdata (IF: we=0, be=all ones, wdata=0), clear counter, go to REQ.
  - REQ: mem_req_valid=1, fields stable from latch. On mem_req_ready go to RSP and drop mem_req_valid next cycle. mem_rsp_valid in REQ, or in the same cycle as acceptance, is ignored (illegal per memory contract).
  - RSP: on mem_rsp_valid, register the owner's rsp_valid=1 (plus rdata) for exactly one cycle, then go to IDLE. Stores also complete through a mem_rsp_valid ack.
- Latency: request sampled in IDLE at cycle T; mem_req_valid at T+1. With ready at T+1 and response at T+2, the owner rsp_valid is at T+3, with the next grant possible in that same T+3 cycle.
- Throughput: one transaction per 3 cycles minimum.
- Stalls: combinational. if_stall = if_req_valid & ~if_rsp_valid; dm_stall = dm_req_valid & ~dm_rsp_valid.
- Flush:
  - if_flush while owner=IF in REQ/RSP sets discard. The bus transaction still completes, since an issued request is never retracted. Its response is dropped: if_rsp_valid stays 0, but the FSM still returns to IDLE.
  - Flush in IDLE, or with owner=DM: no effect.
  - discard clears on entry to IDLE.
- Timeout: counter increments each cycle in REQ/RSP. On reaching TIMEOUT without completion:
  - bus_err=1 for one cycle, simultaneous with the owner rsp_valid=1 and rdata=0 (IF discard still suppresses if_rsp_valid);
  - mem_req_valid drops; state goes to IDLE.
- Response data registers hold their last value when their strobe is low.

Decomposition:
- Shared package risc_v_pkg:
  - arb_state_t {IDLE, REQ, RSP};
  - arb_owner_t {OWN_NONE, OWN_IF, OWN_DM};
  - XLEN/ADDR_W defaults.
- One natural sub-module: mem_arb_watchdog (loadable timeout counter with expire output).

Test Plan:
- IF-only fetch of addr 0x0000_0040; ready same cycle as valid, rsp at T+2 with 0x0050_0093 -> mem_req_addr=0x40, we=0; if_rsp_valid at T+3 with data 0x0050_0093; if_stall high T..T+2.
- Same-cycle IF 0x44 and DM store addr 0x100, wdata 0xDEAD_BEEF, be 0xF -> DM granted first (mem_req_we=1); IF granted in the dm_rsp_valid cycle; if_stall high until its own response.
- mem_req_ready held low 3 cycles during a DM load of addr 0x200 -> mem_req_valid and all fields stable for 4 cycles; dm_rsp_rdata equals mem_rsp_rdata.
- if_flush pulsed during RSP of fetch 0x48 -> if_rsp_valid never asserts; new fetch 0x80 is granted after the dropped response.
- TIMEOUT=8, DM load with no mem_rsp_valid -> bus_err and dm_rsp_valid with rdata=0 exactly 8 cycles after grant; a late mem_rsp_valid is ignored.
- Reset asserted in RSP -> all outputs 0 immediately (asynchronous); after release, a stray mem_rsp_valid produces no strobe.
